// File: rtl/uart_tx_frame.sv
// Serial UART transmitter: start bit, LSB-first data, optional parity bit, one stop bit.
// Latency: TX_OUT drops to the start bit on the acceptance edge; a frame lasts (DATA_WIDTH+2+PAR_EN)*N cycles.
// Backpressure: Busy high from acceptance until the frame ends; Data_Valid while Busy is dropped, not queued.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescaler,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q;
    logic [5:0]            cnt_q;      // cycles spent in the current bit
    logic [5:0]            n_q;        // cycles per bit, latched at acceptance (never 0 in a frame)
    logic [IW-1:0]         idx_q;      // data bit index
    logic [DATA_WIDTH-1:0] sh_q;       // latched word, shifted right as bits go out
    logic                  par_en_q;
    logic                  par_bit_q;  // parity bit precomputed from the latched word and type
    logic                  tx_q;
    logic                  busy_q;
    logic                  bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == (n_q - 6'd1));

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // Frame sequencer; line and Busy are registered here so TX_OUT only moves on posedge CLK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (Data_Valid && !busy_q) begin
                        sh_q      <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= (^P_DATA) ^ PAR_TYP;
                        n_q       <= (Prescaler == 6'd0) ? 6'd1 : Prescaler;
                        idx_q     <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle expected line levels queued at drive time, compared at negedge.
// Latency: expects the start bit on the cycle after Data_Valid is presented while idle.
// Backpressure: verifies Data_Valid during Busy is ignored and a held request gets exactly one idle cycle.
module tb_uart_tx_frame;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescaler;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    logic exp_bits[$];
    int   exp_len[$];
    bit   mon_en = 1'b0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescaler  (Prescaler),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Queue the expected line level for every cycle of one frame, plus its Busy length.
    task automatic expect_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                                input logic [5:0] ps);
        int   n;
        int   ones;
        logic bits[$];
        n = (ps == 6'd0) ? 1 : int'(ps);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        // Even: total ones even; odd: total ones odd.
        if (pen) bits.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < n; c++) exp_bits.push_back(bits[b]);
        exp_len.push_back(bits.size() * n);
    endtask

    // Present one request at a negedge, check it was taken, then scramble inputs.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                        input logic [5:0] ps, input bit track);
        if (track) expect_frame(d, pen, ptyp, ps);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Prescaler  = ps;
        Data_Valid = 1'b1;
        @(negedge CLK);
        check("accept_busy", Busy, 1'b1);
        Data_Valid = 1'b0;
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        Prescaler  = 6'($urandom);
    endtask

    task automatic wait_busy(input logic lvl, input int max_cyc);
        int n;
        n = 0;
        while (Busy !== lvl && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        check("wait_busy", Busy, lvl);
    endtask

    // Monitor: pop one expected level per busy cycle; check frame length when Busy falls.
    initial begin
        bit prev_busy;
        int busy_cnt;
        int exp_l;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                prev_busy = 1'b0;
                busy_cnt  = 0;
            end else if (Busy === 1'b1) begin
                if (exp_bits.size() > 0) check("line_bit", TX_OUT, exp_bits.pop_front());
                else                     check("unexpected_busy", Busy, 1'b0);
                busy_cnt++;
                prev_busy = 1'b1;
            end else begin
                check("idle_line", TX_OUT, 1'b1);
                if (prev_busy) begin
                    exp_l = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
                    check("frame_len", busy_cnt, exp_l);
                end
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end
        end
    end

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescaler  = 6'd8;

        // 1) Reset, then idle line for 100 cycles.
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx", TX_OUT, 1'b1);
        check("rst_busy", Busy, 1'b0);
        RST    = 1'b1;
        mon_en = 1'b1;
        repeat (100) @(negedge CLK);
        check("idle_busy", Busy, 1'b0);

        // 2) 0xA3 even parity, 8 cycles/bit.
        send(8'hA3, 1'b1, 1'b0, 6'd8, 1'b1);
        wait_busy(1'b0, 200);
        repeat (3) @(negedge CLK);

        // 3) 0xD4 odd parity, 8 cycles/bit.
        send(8'hD4, 1'b1, 1'b1, 6'd8, 1'b1);
        wait_busy(1'b0, 200);
        repeat (3) @(negedge CLK);

        // 4+5) 0x51 no parity at 16/bit; a mid-frame pulse is dropped, a held request follows.
        send(8'h51, 1'b0, 1'b0, 6'd16, 1'b1);
        repeat (40) @(negedge CLK);
        P_DATA     = 8'h3C;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (20) @(negedge CLK);
        expect_frame(8'h3C, 1'b1, 1'b1, 6'd4);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Prescaler  = 6'd4;
        Data_Valid = 1'b1;
        wait_busy(1'b0, 300);
        @(negedge CLK);
        check("b2b_accept", Busy, 1'b1);
        Data_Valid = 1'b0;
        wait_busy(1'b0, 200);
        repeat (5) @(negedge CLK);
        check("no_extra_frame", Busy, 1'b0);

        // 6) Asynchronous reset in the middle of data bit 2 (a 0 on the line).
        mon_en = 1'b0;
        send(8'hA3, 1'b1, 1'b0, 6'd8, 1'b0);
        repeat (26) @(negedge CLK);
        check("pre_rst_tx", TX_OUT, 1'b0);
        check("pre_rst_busy", Busy, 1'b1);
        RST = 1'b0;
        #1;
        check("async_rst_tx", TX_OUT, 1'b1);
        check("async_rst_busy", Busy, 1'b0);
        repeat (2) @(negedge CLK);
        check("held_rst_busy", Busy, 1'b0);
        RST    = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK);
        send(8'hA3, 1'b1, 1'b0, 6'd0, 1'b1);
        wait_busy(1'b0, 50);
        repeat (3) @(negedge CLK);

        check("leftover_bits", exp_bits.size(), 0);
        check("leftover_len", exp_len.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
